// File: rtl/inst_fetch.sv
// Fetch stage: issues 1-cycle imem reads from pc_in into a 2-entry tagged buffer for decode.
// Latency 2 clocks issue->inst_valid; issue is credit-gated on buffer+in-flight, so decode stalls stop pc_en.
module inst_fetch #(
   parameter int INST_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int INST_MEM_START = 0,
   parameter int INST_MEM_DEPTH = 512
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [MEM_ADDR_WIDTH-1:0] pc_in,
   output logic                      pc_en,
   output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
   output logic                      imem_rd_en,
   input  logic [INST_WIDTH-1:0]     imem_rdata,
   input  logic                      halt,
   input  logic                      flush,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   output logic [INST_WIDTH-1:0]     inst_out,
   output logic [MEM_ADDR_WIDTH-1:0] inst_pc,
   output logic                      fetch_fault
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [1:0]                cnt_q, cnt_d;
   logic                      inflight_q, inflight_d;
   logic [MEM_ADDR_WIDTH-1:0] tag_q, tag_d;
   logic [INST_WIDTH-1:0]     head_dat_q, head_dat_d;
   logic [MEM_ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
   logic [INST_WIDTH-1:0]     tail_dat_q, tail_dat_d;
   logic [MEM_ADDR_WIDTH-1:0] tail_pc_q, tail_pc_d;

   int         pc_int;
   logic       pc_legal;
   logic [2:0] occ;
   logic       credit_ok;
   logic       run_ok;
   logic       issue;
   logic       bad_pc;
   logic       buf_vld;
   logic       pop;
   logic       push;

   always_comb begin
      pc_int   = int'(pc_in);
      pc_legal = (pc_int >= INST_MEM_START) &&
                 (pc_int < INST_MEM_START + INST_MEM_DEPTH);
   end

   // Credit counts words already buffered plus the one in flight, net of this cycle's pop.
   always_comb begin
      buf_vld   = (cnt_q != 2'd0);
      pop       = buf_vld && inst_ready;
      push      = inflight_q && !flush;
      occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      credit_ok = (occ < 3'd2);
      run_ok    = reset_n && (state_q == ST_RUN) && !halt && !flush;
      issue     = run_ok && pc_legal && credit_ok;
      bad_pc    = run_ok && !pc_legal;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (bad_pc) begin
               state_d = ST_FAULT;
            end
         end
         ST_HALTED: begin
            if (!halt) begin
               state_d = ST_RUN;
            end
         end
         ST_FAULT: begin
            if (flush) begin
               state_d = halt ? ST_HALTED : ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      pc_en       = issue;
      imem_rd_en  = issue;
      imem_addr   = pc_in;
      inst_valid  = buf_vld;
      inst_out    = head_dat_q;
      inst_pc     = head_pc_q;
      fetch_fault = (state_q == ST_FAULT);
   end

   always_comb begin
      inflight_d = issue;
      tag_d      = issue ? pc_in : tag_q;
      cnt_d      = cnt_q;
      head_dat_d = head_dat_q;
      head_pc_d  = head_pc_q;
      tail_dat_d = tail_dat_q;
      tail_pc_d  = tail_pc_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (push) begin
                  head_dat_d = imem_rdata;
                  head_pc_d  = tag_q;
                  cnt_d      = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_dat_d = imem_rdata;
                  head_pc_d  = tag_q;
               end else if (push) begin
                  tail_dat_d = imem_rdata;
                  tail_pc_d  = tag_q;
                  cnt_d      = 2'd2;
               end else if (pop) begin
                  cnt_d = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_dat_d = tail_dat_q;
                  head_pc_d  = tail_pc_q;
                  if (push) begin
                     tail_dat_d = imem_rdata;
                     tail_pc_d  = tag_q;
                  end else begin
                     cnt_d = 2'd1;
                  end
               end
            end
            default: cnt_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= 2'd0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         head_dat_q <= '0;
         head_pc_q  <= '0;
         tail_dat_q <= '0;
         tail_pc_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         head_dat_q <= head_dat_d;
         head_pc_q  <= head_pc_d;
         tail_dat_q <= tail_dat_d;
         tail_pc_q  <= tail_pc_d;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(push && !pop && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: PC counter and imem (mem[i]=i*4) modelled here, pops logged per cycle.
module tb_inst_fetch;

   logic        clk;
   logic        reset_n;
   logic [9:0]  pc;
   logic        pc_en;
   logic [9:0]  imem_addr;
   logic        imem_rd_en;
   logic [31:0] imem_rdata = '0;
   logic        halt;
   logic        flush;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [9:0]  inst_pc;
   logic        fetch_fault;

   logic [9:0]  pc_rst_val;
   logic        pc_load;
   logic [9:0]  load_val;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_issue = 0;
   logic [9:0]  pop_pc[$];
   logic [31:0] pop_dat[$];

   inst_fetch dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc_in       (pc),
      .pc_en       (pc_en),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_rdata  (imem_rdata),
      .halt        (halt),
      .flush       (flush),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)     pc <= pc_rst_val;
      else if (pc_load) pc <= load_val;
      else if (pc_en)   pc <= pc + 10'd1;
   end

   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= {20'd0, imem_addr, 2'b00};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs set; logs this cycle's handshakes, returns at the next negedge.
   task automatic cyc();
      #1;
      if (inst_valid && inst_ready) begin
         pop_pc.push_back(inst_pc);
         pop_dat.push_back(inst_out);
      end
      if (pc_en) n_issue++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [9:0] start);
      pc_rst_val = start;
      reset_n    = 1'b0;
      halt       = 1'b0;
      flush      = 1'b0;
      pc_load    = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      pop_pc.delete();
      pop_dat.delete();
      n_issue = 0;
   endtask

   function automatic logic [9:0] qpc(input int i);
      return (i < pop_pc.size()) ? pop_pc[i] : 10'h3ff;
   endfunction

   function automatic logic [31:0] qdat(input int i);
      return (i < pop_dat.size()) ? pop_dat[i] : 32'hffffffff;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      halt       = 1'b0;
      flush      = 1'b0;
      inst_ready = 1'b1;
      pc_load    = 1'b0;
      load_val   = '0;
      pc_rst_val = '0;
      #2;
      chk("rst_pc_en", pc_en, 0);
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_out", inst_out, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_fault", fetch_fault, 0);

      // Streaming with decode always ready
      inst_ready = 1'b1;
      do_reset(10'd0);
      #1;
      chk("t1_pc_en_first", pc_en, 1);
      chk("t1_rd_en_first", imem_rd_en, 1);
      chk("t1_addr_first", imem_addr, 0);
      cyc();
      chk("t1_valid_c1", inst_valid, 0);
      cyc();
      chk("t1_valid_c2", inst_valid, 1);
      chk("t1_pc0", inst_pc, 0);
      chk("t1_dat0", inst_out, 0);
      cyc();
      chk("t1_pc1", inst_pc, 1);
      chk("t1_dat1", inst_out, 4);
      cyc();
      chk("t1_pc2", inst_pc, 2);
      chk("t1_dat2", inst_out, 8);
      chk("t1_issues", n_issue, 4);

      // Decode stall: two issues fill the credit, then release
      inst_ready = 1'b0;
      do_reset(10'd0);
      repeat (5) cyc();
      #1;
      chk("t2_issues", n_issue, 2);
      chk("t2_pc_en_stall", pc_en, 0);
      chk("t2_valid", inst_valid, 1);
      chk("t2_hold_pc", inst_pc, 0);
      chk("t2_hold_dat", inst_out, 0);
      inst_ready = 1'b1;
      pop_pc.delete();
      pop_dat.delete();
      repeat (3) cyc();
      chk("t2_npop", pop_pc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t2_pop_pc", qpc(i), i);
         chk("t2_pop_dat", qdat(i), i * 4);
      end

      // Flush at the PC 7 issue cycle, redirected to PC 100
      inst_ready = 1'b1;
      do_reset(10'd0);
      for (int i = 0; i < 20 && pc != 10'd7; i++) cyc();
      chk("t3_reach7", pc, 7);
      flush    = 1'b1;
      pc_load  = 1'b1;
      load_val = 10'd100;
      #1;
      chk("t3_pc_en_flush", pc_en, 0);
      cyc();
      flush   = 1'b0;
      pc_load = 1'b0;
      pop_pc.delete();
      pop_dat.delete();
      #1;
      chk("t3_valid_after", inst_valid, 0);
      chk("t3_resume", pc_en, 1);
      chk("t3_resume_addr", imem_addr, 100);
      repeat (4) cyc();
      chk("t3_npop", pop_pc.size(), 2);
      chk("t3_first_pc", qpc(0), 100);
      chk("t3_first_dat", qdat(0), 400);
      chk("t3_second_pc", qpc(1), 101);

      // Illegal PC 512 after 510, 511
      inst_ready = 1'b1;
      do_reset(10'd510);
      #1;
      chk("t4_pc_en_510", pc_en, 1);
      cyc();
      cyc();
      #1;
      chk("t4_pc512", pc, 512);
      chk("t4_rd_en_illegal", imem_rd_en, 0);
      chk("t4_pc_en_illegal", pc_en, 0);
      chk("t4_fault_same", fetch_fault, 0);
      cyc();
      chk("t4_fault_next", fetch_fault, 1);
      chk("t4_head511", inst_pc, 511);
      repeat (3) cyc();
      chk("t4_npop", pop_pc.size(), 2);
      chk("t4_pop0_pc", qpc(0), 510);
      chk("t4_pop0_dat", qdat(0), 2040);
      chk("t4_pop1_pc", qpc(1), 511);
      chk("t4_pop1_dat", qdat(1), 2044);
      chk("t4_drained", inst_valid, 0);
      chk("t4_rd_en_fault", imem_rd_en, 0);
      chk("t4_fault_sticky", fetch_fault, 1);
      flush    = 1'b1;
      pc_load  = 1'b1;
      load_val = 10'd20;
      cyc();
      flush   = 1'b0;
      pc_load = 1'b0;
      #1;
      chk("t4_fault_clear", fetch_fault, 0);
      chk("t4_refetch", pc_en, 1);

      // Halt for 3 cycles mid-stream
      inst_ready = 1'b1;
      do_reset(10'd0);
      repeat (4) cyc();
      pop_pc.delete();
      pop_dat.delete();
      n_issue = 0;
      halt = 1'b1;
      repeat (3) cyc();
      halt = 1'b0;
      #1;
      chk("t5_pc_en_release", pc_en, 0);
      cyc();
      chk("t5_issue_halt", n_issue, 0);
      #1;
      chk("t5_resume", pc_en, 1);
      chk("t5_resume_addr", imem_addr, 4);
      repeat (3) cyc();
      chk("t5_npop", pop_pc.size(), 3);
      chk("t5_pop0", qpc(0), 2);
      chk("t5_pop_inflight", qpc(1), 3);
      chk("t5_pop_resume", qpc(2), 4);
      chk("t5_dat_resume", qdat(2), 16);

      // Asynchronous reset mid-cycle with the buffer full
      inst_ready = 1'b0;
      do_reset(10'd300);
      repeat (4) cyc();
      #1;
      chk("t6_full_valid", inst_valid, 1);
      chk("t6_full_dat", inst_out, 1200);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_valid_async", inst_valid, 0);
      chk("t6_pc_en_async", pc_en, 0);
      chk("t6_fault_async", fetch_fault, 0);
      chk("t6_out_async", inst_out, 0);
      chk("t6_pc_async", inst_pc, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
